sobel_sequencer: RTL and testbench

SOBEL_SEQUENCER -- requirements
Module: sobel_sequencer

---
 rtl/sobel_sequencer_pkg.sv | 19 +
 rtl/sobel_addr_gen.sv | 45 ++++
 rtl/sobel_sequencer.sv | 152 +++++++++++++++
 tb/tb_sobel_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_sequencer_pkg.sv
// Shared frame definitions: frame geometry defaults, pixel/window sizes and
// the sequencer state encoding, used by the edge sequencer, buffers and VGA read side.
package sobel_sequencer_pkg;

  localparam int IMG_W_DEF  = 150;
  localparam int IMG_H_DEF  = 150;
  localparam int ADDR_W_DEF = 15;
  localparam int PIX_W      = 8;
  localparam int WIN_N      = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EVAL,
    WRITE
  } state_e;

endpackage

// File: rtl/sobel_addr_gen.sv
// Window address generator: maps target (i,j) and window tap k to the
// grayscale buffer address, and (i,j) to the target address.
module sobel_addr_gen
  import sobel_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_i,
  input  logic [ADDR_W-1:0] j_i,
  input  logic [3:0]        k_i,
  output logic [ADDR_W-1:0] win_addr_o,
  output logic [ADDR_W-1:0] tgt_addr_o
);

  localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_W);

  logic [1:0]        row_off;
  logic [1:0]        col_off;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  // k/3 and k%3 without a divider; taps beyond 8 never reach the output register.
  always_comb begin
    row_off = 2'd0;
    col_off = 2'd0;
    case (k_i)
      4'd1: col_off = 2'd1;
      4'd2: col_off = 2'd2;
      4'd3: row_off = 2'd1;
      4'd4: begin row_off = 2'd1; col_off = 2'd1; end
      4'd5: begin row_off = 2'd1; col_off = 2'd2; end
      4'd6: row_off = 2'd2;
      4'd7: begin row_off = 2'd2; col_off = 2'd1; end
      4'd8: begin row_off = 2'd2; col_off = 2'd2; end
      default: begin row_off = 2'd0; col_off = 2'd0; end
    endcase
  end

  assign row        = i_i + ADDR_W'(row_off) - ADDR_W'(1);
  assign col        = j_i + ADDR_W'(col_off) - ADDR_W'(1);
  assign win_addr_o = row * W + col;
  assign tgt_addr_o = i_i * W + j_i;

endmodule

// File: rtl/sobel_sequencer.sv
// Edge-detection pass sequencer: walks every target pixel, fetches its 3x3
// window for interior targets, thresholds the Sobel result and writes one edge bit.
module sobel_sequencer
  import sobel_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PIX_W-1:0]         threshold,
  output logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [PIX_W-1:0]         rd_data_a,
  output logic [PIX_W*WIN_N-1:0]   win_pix,
  input  logic [PIX_W-1:0]         sobel_in,
  output logic                     wr_en_b,
  output logic [ADDR_W-1:0]        wr_addr_b,
  output logic                     wr_data_b,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(IMG_W - 1);
  localparam logic [3:0]        K_LAST = 4'(WIN_N - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] i_q, j_q;
  logic [ADDR_W-1:0] i_d, j_d;
  logic [ADDR_W-1:0] tgt_i, tgt_j;
  logic [ADDR_W-1:0] win_addr, tgt_addr;
  logic [3:0]        k_q, k_gen;
  logic              tgt_border, last_tgt, enter_tgt;
  logic              busy_q, done_q, wr_en_q, wr_data_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [PIX_W-1:0]  p_q [WIN_N];

  // tgt_* is the target being entered this cycle: (0,0) from IDLE, the
  // successor from WRITE, otherwise the current target.
  always_comb begin
    i_d   = (j_q == LAST_J) ? i_q + ADDR_W'(1) : i_q;
    j_d   = (j_q == LAST_J) ? '0 : j_q + ADDR_W'(1);
    tgt_i = i_q;
    tgt_j = j_q;
    case (state_q)
      IDLE:    begin tgt_i = '0;  tgt_j = '0;  end
      WRITE:   begin tgt_i = i_d; tgt_j = j_d; end
      default: begin tgt_i = i_q; tgt_j = j_q; end
    endcase
    k_gen      = (state_q == FETCH) ? k_q + 4'd1 : 4'd0;
    tgt_border = (tgt_i == '0) || (tgt_i == LAST_I) || (tgt_j == '0) || (tgt_j == LAST_J);
    last_tgt   = (i_q == LAST_I) && (j_q == LAST_J);
    enter_tgt  = ((state_q == IDLE) && start) || ((state_q == WRITE) && !last_tgt);
  end

  sobel_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_i        (tgt_i),
    .j_i        (tgt_j),
    .k_i        (k_gen),
    .win_addr_o (win_addr),
    .tgt_addr_o (tgt_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      for (int n = 0; n < WIN_N; n++) p_q[n] <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        k_q     <= '0;
      end else begin
        case (state_q)
          IDLE: busy_q <= start;
          FETCH: begin
            // Read data lags its address by one cycle, so tap k-1 lands now.
            if (k_q != 4'd0) p_q[k_q - 4'd1] <= rd_data_a;
            if (k_q == K_LAST) begin
              state_q <= WAIT;
            end else begin
              k_q       <= k_gen;
              rd_addr_q <= win_addr;
            end
          end
          WAIT: begin
            p_q[WIN_N-1] <= rd_data_a;
            state_q      <= EVAL;
          end
          EVAL: begin
            wr_data_q <= (sobel_in >= threshold);
            wr_en_q   <= 1'b1;
            wr_addr_q <= tgt_addr;
            state_q   <= WRITE;
          end
          WRITE: begin
            if (last_tgt) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase

        if (enter_tgt) begin
          i_q <= tgt_i;
          j_q <= tgt_j;
          if (tgt_border) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_addr_q <= tgt_addr;
            wr_data_q <= 1'b0;
          end else begin
            state_q   <= FETCH;
            k_q       <= 4'd0;
            rd_addr_q <= win_addr;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < WIN_N; gi++) begin : g_win
    assign win_pix[PIX_W*gi +: PIX_W] = p_q[gi];
  end

  assign rd_addr_a = rd_addr_q;
  assign wr_en_b   = wr_en_q & ~abort;
  assign wr_addr_b = wr_addr_q;
  assign wr_data_b = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sobel_sequencer.sv
// Bench for sobel_sequencer on a reduced 8x6 frame with a registered-read
// grayscale buffer and a behavioural Sobel magnitude core.
module tb_sobel_sequencer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int AW   = 15;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    threshold = 8'd0;
  logic [7:0]    rd_data_a = 8'd0;
  logic [7:0]    sobel_in;
  logic [AW-1:0] rd_addr_a, wr_addr_b;
  logic [71:0]   win_pix;
  logic          wr_en_b, wr_data_b, busy, done;

  logic [7:0] img [NPIX];
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int kind;      // 0 uniform, 1 vertical step, 2 horizontal step
    int step;      // first column/row holding amp
    int amp;
    int thr;
    int exp_ones;
    int exp_done;
  } vec_t;

  vec_t tbl[6];

  sobel_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .threshold (threshold),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .win_pix   (win_pix),
    .sobel_in  (sobel_in),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data_a <= (rd_addr_a < NPIX) ? img[rd_addr_a[5:0]] : 8'h00;

  function automatic logic [7:0] sobel_model(input logic [71:0] w);
    int p[9];
    int gx, gy, m;
    for (int n = 0; n < 9; n++) p[n] = int'(w[8*n +: 8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 8'd255 : m[7:0];
  endfunction

  always_comb sobel_in = sobel_model(win_pix);

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // A step of height amp gives |gx| or |gy| = 4*amp on the two pixels
  // straddling it and 0 elsewhere; flat regions give 0.
  function automatic logic exp_edge(input vec_t v, input int i, input int j);
    logic interior;
    logic hit;
    int   mag;
    interior = (i > 0) && (i < H-1) && (j > 0) && (j < W-1);
    hit = ((v.kind == 1) && (j == v.step-1 || j == v.step)) ||
          ((v.kind == 2) && (i == v.step-1 || i == v.step));
    mag = hit ? ((4*v.amp > 255) ? 255 : 4*v.amp) : 0;
    return interior && (mag >= v.thr);
  endfunction

  task automatic fill_image(input vec_t v);
    for (int n = 0; n < NPIX; n++) begin
      int i, j, val;
      i = n / W;
      j = n % W;
      case (v.kind)
        1:       val = (j < v.step) ? 0 : v.amp;
        2:       val = (i < v.step) ? 0 : v.amp;
        default: val = v.amp;
      endcase
      img[n] = val[7:0];
    end
    threshold = v.thr[7:0];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic watch(input int n, input string tag);
    int nw = 0, nd = 0, nb = 0;
    repeat (n) begin
      @(negedge clk);
      nw += int'(wr_en_b);
      nd += int'(done);
      nb += int'(busy);
    end
    check({tag, " writes"}, 72'(nw), 72'(0));
    check({tag, " dones"}, 72'(nd), 72'(0));
    check({tag, " busy cycles"}, 72'(nb), 72'(0));
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int nwr = 0, nones = 0, acc = 0, done_cyc = -1, bad = 0;
    fill_image(v);
    pulse_start();
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      if (rd_addr_a >= NPIX) bad++;
      if (cyc == 1) check({tag, " busy after start"}, 72'(busy), 72'(1));
      if (wr_en_b) begin
        int i, j;
        logic border, e;
        i = nwr / W;
        j = nwr % W;
        border = (i == 0) || (i == H-1) || (j == 0) || (j == W-1);
        acc += border ? 1 : 12;
        e = exp_edge(v, i, j);
        n_vec++;
        if (wr_addr_b !== AW'(nwr) || cyc != acc || wr_data_b !== e) begin
          n_miss++;
          $display("FAIL %s write %0d: addr %0d cyc %0d data %b, expected addr %0d cyc %0d data %b",
                   tag, nwr, wr_addr_b, cyc, wr_data_b, nwr, acc, e);
        end
        nones += int'(wr_data_b);
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        check({tag, " busy at done"}, 72'(busy), 72'(0));
        break;
      end
    end
    check({tag, " write count"}, 72'(nwr), 72'(NPIX));
    check({tag, " edge count"}, 72'(nones), 72'(v.exp_ones));
    check({tag, " done cycle"}, 72'(done_cyc), 72'(v.exp_done));
    check({tag, " read addr range"}, 72'(bad), 72'(0));
  endtask

  initial begin
    int fetch_exp[9];
    logic [AW-1:0] addr0;
    int changed, nwr, ndone, done_cyc;

    fetch_exp = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    //            kind step amp thr ones done
    tbl[0] = '{0, 0, 100,  50,  0, 313};
    tbl[1] = '{1, 4, 200, 128,  8, 313};
    tbl[2] = '{2, 3, 200, 128, 12, 313};
    tbl[3] = '{1, 4,  30, 120,  8, 313};
    tbl[4] = '{1, 4,  30, 121,  0, 313};
    tbl[5] = '{0, 0, 100,   0, 24, 313};

    repeat (3) @(negedge clk);
    check("reset busy", 72'(busy), 72'(0));
    check("reset done", 72'(done), 72'(0));
    check("reset wr_en_b", 72'(wr_en_b), 72'(0));
    check("reset wr_data_b", 72'(wr_data_b), 72'(0));
    check("reset rd_addr_a", 72'(rd_addr_a), 72'(0));
    check("reset wr_addr_b", 72'(wr_addr_b), 72'(0));
    check("reset win_pix", win_pix, 72'(0));
    rst_n = 1'b1;
    watch(5, "idle after reset");

    for (int t = 0; t < 6; t++) run_pass(tbl[t], $sformatf("vec%0d", t));

    // Fetch order for target (1,1), quiet read port on borders, starts ignored while busy.
    fill_image(tbl[0]);
    @(negedge clk);
    addr0 = rd_addr_a;
    pulse_start();
    changed = 0; nwr = 0; ndone = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 340; cyc++) begin
      @(negedge clk);
      if (cyc <= 9 && rd_addr_a !== addr0) changed++;
      if (cyc >= 10 && cyc <= 18)
        check($sformatf("fetch(1,1) tap %0d", cyc-10), 72'(rd_addr_a), 72'(fetch_exp[cyc-10]));
      nwr += int'(wr_en_b);
      if (done) begin ndone++; done_cyc = cyc; end
      start = (cyc == 100) || (cyc == 200);
    end
    start = 1'b0;
    check("border rd_addr_a activity", 72'(changed), 72'(0));
    check("restart-ignored write count", 72'(nwr), 72'(NPIX));
    check("restart-ignored done count", 72'(ndone), 72'(1));
    check("restart-ignored done cycle", 72'(done_cyc), 72'(313));

    // Abort landing on the WRITE cycle of target (1,3).
    pulse_start();
    repeat (44) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort-cycle wr_en_b", 72'(wr_en_b), 72'(0));
    check("abort-cycle busy", 72'(busy), 72'(1));
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("busy after abort", 72'(busy), 72'(0));
    watch(350, "after abort");

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    watch(20, "start+abort");

    // Asynchronous reset in the middle of a pass.
    pulse_start();
    repeat (59) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset busy", 72'(busy), 72'(0));
    check("midreset wr_en_b", 72'(wr_en_b), 72'(0));
    check("midreset rd_addr_a", 72'(rd_addr_a), 72'(0));
    check("midreset win_pix", win_pix, 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(350, "after reset");

    run_pass(tbl[1], "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
